// File: rtl/dram_cmd_scheduler_if.sv
// Request-queue / command-bus bundle for the DDR4 command scheduler.
// Handshake: a request transfers on a clk edge where req_valid && req_ready; req_addr/req_opcode matter only then.
interface dram_cmd_scheduler_if;
  logic        req_valid;
  logic [1:0]  req_opcode;
  logic [32:0] req_addr;
  logic        req_ready;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done;
  logic        busy;
  logic [3:0]  dbg_state;

  modport master (
    output req_valid, req_opcode, req_addr,
    input  req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_opcode, req_addr,
    output req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, done, busy, dbg_state
  );
endinterface

// File: rtl/dram_cmd_scheduler.sv
// One-request-at-a-time DDR4 command sequencer (PRE/ACT/RD/WR) with an open-page
// table of 16 banks and per-bank PRE blocking counters.
module dram_cmd_scheduler #(
  parameter int T_RCD   = 24,
  parameter int T_RP    = 24,
  parameter int T_RAS   = 52,
  parameter int T_CL    = 24,
  parameter int T_CWL   = 20,
  parameter int T_BURST = 4,
  parameter int T_WR    = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  dram_cmd_scheduler_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, DECODE, WAIT_RAS, PRE, WAIT_RP, ACT, WAIT_RCD, COL, WAIT_DATA
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  // Wait loads are one less than the spacing because the issuing state itself is one cycle.
  localparam logic [7:0] RP_LD    = 8'(T_RP - 1);
  localparam logic [7:0] RCD_LD   = 8'(T_RCD - 1);
  localparam logic [7:0] RD_LAT   = 8'(T_CL + T_BURST);
  localparam logic [7:0] WR_LAT   = 8'(T_CWL + T_BURST);
  localparam logic [7:0] RAS_LD   = 8'(T_RAS);
  localparam logic [7:0] WR_BLOCK = 8'(T_CWL + T_BURST + T_WR);

  state_t      state, state_n;
  logic        ready_en;
  logic        req_wr;
  logic [14:0] req_row;
  logic [9:0]  req_col;
  logic [3:0]  req_bidx;
  logic [7:0]  wait_cnt;
  logic [15:0] bank_open;
  logic [14:0] open_row  [16];
  logic [7:0]  pre_block [16];

  logic       accept;
  logic       issue_pre, issue_act, issue_col, done_c;
  logic       wait_ld;
  logic [7:0] wait_val;
  logic       unused_addr;

  assign unused_addr = ^bus.req_addr[3:0];
  assign accept = (state == IDLE) && ready_en && bus.req_valid;

  always_comb begin
    state_n   = state;
    issue_pre = 1'b0;
    issue_act = 1'b0;
    issue_col = 1'b0;
    done_c    = 1'b0;
    wait_ld   = 1'b0;
    wait_val  = 8'd0;
    case (state)
      IDLE:     if (accept) state_n = DECODE;
      DECODE: begin
        if (!bank_open[req_bidx])                    state_n = ACT;
        else if (open_row[req_bidx] == req_row)      state_n = COL;
        else if (pre_block[req_bidx] == 8'd0)        state_n = PRE;
        else                                         state_n = WAIT_RAS;
      end
      WAIT_RAS: if (pre_block[req_bidx] == 8'd0) state_n = PRE;
      PRE: begin
        issue_pre = 1'b1;
        wait_ld   = 1'b1;
        wait_val  = RP_LD;
        state_n   = (T_RP == 1) ? ACT : WAIT_RP;
      end
      WAIT_RP:  if (wait_cnt <= 8'd1) state_n = ACT;
      ACT: begin
        issue_act = 1'b1;
        wait_ld   = 1'b1;
        wait_val  = RCD_LD;
        state_n   = (T_RCD == 1) ? COL : WAIT_RCD;
      end
      WAIT_RCD: if (wait_cnt <= 8'd1) state_n = COL;
      COL: begin
        issue_col = 1'b1;
        wait_ld   = 1'b1;
        wait_val  = req_wr ? WR_LAT : RD_LAT;
        state_n   = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (wait_cnt <= 8'd1) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      wait_cnt <= 8'd0;
      req_wr   <= 1'b0;
      req_row  <= '0;
      req_col  <= '0;
      req_bidx <= '0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      if (wait_ld)              wait_cnt <= wait_val;
      else if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
      if (accept) begin
        req_wr   <= (bus.req_opcode == 2'd1);
        req_row  <= bus.req_addr[32:18];
        req_col  <= {bus.req_addr[17:10], bus.req_addr[5:4]};
        req_bidx <= {bus.req_addr[7:6], bus.req_addr[9:8]};
      end
    end
  end

  // Open-page table and PRE blocking counters; a load beats the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int i = 0; i < 16; i++) begin
        open_row[i]  <= '0;
        pre_block[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (issue_act && (req_bidx == 4'(i)))
          pre_block[i] <= RAS_LD;
        else if (issue_col && req_wr && (req_bidx == 4'(i)))
          pre_block[i] <= (pre_block[i] > WR_BLOCK) ? pre_block[i] : WR_BLOCK;
        else if (pre_block[i] != 8'd0)
          pre_block[i] <= pre_block[i] - 8'd1;
      end
      if (issue_pre) bank_open[req_bidx] <= 1'b0;
      if (issue_act) begin
        bank_open[req_bidx] <= 1'b1;
        open_row[req_bidx]  <= req_row;
      end
    end
  end

  logic issue_any;
  assign issue_any = issue_pre | issue_act | issue_col;

  always_comb begin
    bus.cmd = CMD_NOP;
    if (issue_act)      bus.cmd = CMD_ACT;
    else if (issue_pre) bus.cmd = CMD_PRE;
    else if (issue_col) bus.cmd = req_wr ? CMD_WR : CMD_RD;
  end

  assign bus.req_ready = (state == IDLE) && ready_en;
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_valid = issue_any;
  assign bus.cmd_bg    = issue_any ? req_bidx[3:2] : 2'd0;
  assign bus.cmd_bank  = issue_any ? req_bidx[1:0] : 2'd0;
  assign bus.cmd_row   = issue_act ? req_row : 15'd0;
  assign bus.cmd_col   = issue_col ? req_col : 10'd0;
  assign bus.done      = done_c;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: directed steps then random requests, checked against
// a timeline model that computes command cycles from the timing rules.
module tb_dram_cmd_scheduler;
  localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24;
  localparam int T_CWL = 20, T_BURST = 4, T_WR = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_cmd_scheduler_if bus();
  dram_cmd_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  logic [63:0] exp_q[$];

  // Model: per-bank open row and the first cycle at which its PRE blocker reads zero.
  bit m_open [16];
  int m_row  [16];
  int m_zero [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
      m_zero[i] = 0;
    end
  endtask

  function automatic logic [32:0] mk_addr(input int row, input int bg, input int bank, input int col);
    logic [32:0] a;
    logic [9:0]  c;
    c = 10'(col);
    a = '0;
    a[32:18] = 15'(row);
    a[17:10] = c[9:2];
    a[9:8]   = 2'(bank);
    a[7:6]   = 2'(bg);
    a[5:4]   = c[1:0];
    a[3:0]   = 4'($urandom_range(0, 15));
    return a;
  endfunction

  task automatic push_cmd(input int cyc, input int cmd, input int b, input int row, input int col);
    exp_q.push_back({32'(cyc), 3'(cmd), 4'(b), 15'(row), 10'(col)});
  endtask

  task automatic predict(input logic [1:0] op, input logic [32:0] addr, input int t0, output int done_at);
    int b, r, c, pre, act, cc, v;
    bit wr;
    r  = int'(addr[32:18]);
    c  = int'({addr[17:10], addr[5:4]});
    b  = int'({addr[7:6], addr[9:8]});
    wr = (op == 2'd1);
    if (m_open[b] && m_row[b] == r) begin
      cc = t0 + 2;
    end else begin
      if (m_open[b]) begin
        pre = (t0 + 2 > m_zero[b] + 1) ? t0 + 2 : m_zero[b] + 1;
        push_cmd(pre, 4, b, 0, 0);
        act = pre + T_RP;
      end else begin
        act = t0 + 2;
      end
      push_cmd(act, 1, b, r, 0);
      m_open[b] = 1'b1;
      m_row[b]  = r;
      m_zero[b] = act + 1 + T_RAS;
      cc = act + T_RCD;
    end
    push_cmd(cc, wr ? 3 : 2, b, 0, c);
    if (wr) begin
      v = (m_zero[b] > cc) ? m_zero[b] - cc : 0;
      m_zero[b] = cc + 1 + ((v > T_CWL + T_BURST + T_WR) ? v : T_CWL + T_BURST + T_WR);
    end
    done_at = cc + (wr ? T_CWL + T_BURST : T_CL + T_BURST);
  endtask

  // Issues one request, tracks every command until done; abort_at > 0 pulls reset that many cycles after accept.
  task automatic do_req(input logic [1:0] op, input logic [32:0] addr, input int abort_at, output int lat);
    int guard, t0, done_at, n_done_rst;
    bit got_done, aborted;
    logic [63:0] obs;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_addr   = addr;
    t0 = ncyc;
    predict(op, addr, t0, done_at);
    tick();
    bus.req_valid  = 1'b0;
    bus.req_opcode = 2'($urandom_range(0, 3));
    bus.req_addr   = 33'($urandom);
    chk("req_ready_busy", {63'd0, bus.req_ready, 1'b0} | 64'(bus.busy), 64'd1);
    got_done = 1'b0;
    aborted  = 1'b0;
    lat = -1;
    while (!got_done && !aborted && ncyc < t0 + 400) begin
      obs = {32'(ncyc), bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col};
      if (bus.cmd_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("cmd_unexpected", obs, 64'd0);
        else                   chk("cmd", obs, exp_q.pop_front());
      end
      if (bus.done === 1'b1) begin
        chk("done_cycle", 64'(ncyc), 64'(done_at));
        chk("done_ready_low", 64'(bus.req_ready), 64'd0);
        lat = ncyc - t0;
        got_done = 1'b1;
      end else if (abort_at > 0 && ncyc == t0 + abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {59'd0, bus.cmd_valid, bus.req_ready, bus.busy, bus.done, 1'b0}, 64'd0);
        chk("rst_cmd_fields", {29'd0, bus.cmd, bus.cmd_bg, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 64'd0);
        exp_q.delete();
        model_reset();
        n_done_rst = 0;
        repeat (3) begin
          tick();
          if (bus.done !== 1'b0) n_done_rst++;
        end
        rst_n = 1'b1;
        repeat (3) begin
          tick();
          if (bus.done !== 1'b0) n_done_rst++;
        end
        chk("rst_no_done", 64'(n_done_rst), 64'd0);
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    if (!aborted) begin
      chk("done_seen", 64'(got_done), 64'd1);
      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tick();
    end
  endtask

  initial begin
    int lat, gap, row, bg, bank, col;
    logic [1:0] op;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 2'd0;
    bus.req_addr   = '0;
    model_reset();

    // Reset state
    #2;
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_outputs", {60'd0, bus.cmd_valid, bus.busy, bus.done, bus.cmd != 3'd0}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_ready", {62'd0, bus.req_ready, bus.busy}, 64'b10);

    // Read to an empty bank: ACT +2, RD +26, done +54
    do_req(2'd0, 33'h0_0004_0040, 0, lat);
    chk("empty_read_latency", 64'(lat), 64'd54);

    // Write hit on the same row, different column: WR +2, done +26
    do_req(2'd1, mk_addr(1, 1, 0, 37), 0, lat);
    chk("hit_write_latency", 64'(lat), 64'd26);

    // Miss right after the write: held in WAIT_RAS by the write's blocker
    do_req(2'd0, mk_addr(2, 1, 0, 5), 0, lat);
    chk("miss_after_write_latency", 64'(lat), 64'd97);

    // Miss long after ACT with no write: PRE +2, ACT +26, RD +50, done +78
    do_req(2'd2, mk_addr(5, 2, 1, 9), 0, lat);
    repeat (10) tick();
    do_req(2'd3, mk_addr(6, 2, 1, 10), 0, lat);
    chk("miss_no_block_latency", 64'(lat), 64'd78);

    // Two banks back to back, then a hit proves the first stayed open
    do_req(2'd0, mk_addr(7, 0, 3, 100), 0, lat);
    do_req(2'd0, mk_addr(9, 3, 2, 200), 0, lat);
    chk("second_bank_empty_latency", 64'(lat), 64'd54);
    do_req(2'd0, mk_addr(7, 0, 3, 300), 0, lat);
    chk("first_bank_hit_latency", 64'(lat), 64'd30);

    // Reset 30 cycles into a miss; the bank must then take the empty path
    do_req(2'd0, mk_addr(8, 0, 3, 4), 30, lat);
    do_req(2'd0, mk_addr(8, 0, 3, 4), 0, lat);
    chk("after_reset_empty_latency", 64'(lat), 64'd54);

    // Random traffic over a few banks and rows to mix hits, misses and empties
    for (int k = 0; k < 40; k++) begin
      row  = $urandom_range(0, 3);
      bg   = $urandom_range(0, 3);
      bank = $urandom_range(0, 1);
      col  = $urandom_range(0, 1023);
      op   = 2'($urandom_range(0, 3));
      gap  = ($urandom_range(0, 5) == 0) ? 70 : $urandom_range(0, 3);
      repeat (gap) tick();
      do_req(op, mk_addr(row, bg, bank, col), 0, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
